// File: rtl/icache_pkg.sv
// Shared types and width helpers for the multi-line instruction cache.
package icache_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StFill = 1'b1
  } icache_state_e;

  localparam logic [7:0] NopOpDefault = 8'hC8;

  function automatic int unsigned offset_w(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  function automatic int unsigned index_w(input int unsigned num_lines);
    return $clog2(num_lines);
  endfunction

  // Signed so that an address too narrow for index+offset shows up as < 1.
  function automatic int tag_w(input int unsigned addr_w, input int unsigned num_lines,
                               input int unsigned line_words);
    return int'(addr_w) - int'($clog2(num_lines)) - int'($clog2(line_words));
  endfunction

endpackage

// File: rtl/icache_fill_ctrl.sv
// Line-fill sequencer: fill counter, registered program-memory address,
// array write strobes and the end-of-fill pulse.
module icache_fill_ctrl
  import icache_pkg::*;
#(
  parameter int unsigned AddrW   = 8,
  parameter int unsigned OffsetW = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic                       active_i,
  input  logic                       abort_i,
  input  logic [AddrW-OffsetW-1:0]   base_i,
  output logic [AddrW-1:0]           pm_address_o,
  output logic                       we_o,
  output logic [OffsetW-1:0]         wr_off_o,
  output logic                       done_o
);

  localparam int unsigned FcW = OffsetW + 1;
  localparam logic [FcW-1:0] FcOne  = FcW'(1);
  localparam logic [FcW-1:0] FcLast = FcW'(2 ** OffsetW);

  logic [FcW-1:0]   fc_q, fc_d, fc_inc, fc_dec;
  logic [AddrW-1:0] pm_address_q, pm_address_d;

  assign fc_inc = fc_q + FcOne;
  assign fc_dec = fc_q - FcOne;

  always_comb begin
    fc_d         = fc_q;
    pm_address_d = pm_address_q;
    if (start_i) begin
      fc_d         = '0;
      pm_address_d = {base_i, {OffsetW{1'b0}}};
    end else if (active_i) begin
      if (abort_i || (fc_q == FcLast)) begin
        fc_d = '0;
      end else begin
        fc_d = fc_inc;
        // The final step only collects data; the address stays on the last word.
        if (fc_inc != FcLast) begin
          pm_address_d = {base_i, fc_inc[OffsetW-1:0]};
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fc_q         <= '0;
      pm_address_q <= '0;
    end else begin
      fc_q         <= fc_d;
      pm_address_q <= pm_address_d;
    end
  end

  // Word presented at step k arrives one cycle later and is stored at step k+1.
  assign we_o         = active_i && (fc_q != '0) && !abort_i;
  assign wr_off_o     = fc_dec[OffsetW-1:0];
  assign done_o       = active_i && (fc_q == FcLast) && !abort_i;
  assign pm_address_o = pm_address_q;

endmodule

// File: rtl/multi_line_icache.sv
// Direct-mapped multi-line instruction cache with burst line fill and flush.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module multi_line_icache
  import icache_pkg::*;
#(
  parameter int unsigned     ADDR_W     = 8,
  parameter int unsigned     DATA_W     = 8,
  parameter int unsigned     NUM_LINES  = 4,
  parameter int unsigned     LINE_WORDS = 16,
  parameter logic [DATA_W-1:0] NOP_OP   = DATA_W'(NopOpDefault)
) (
  input  logic              clk,
  input  logic              sync_reset_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              fetch_en,
  input  logic              flush,
  output logic [DATA_W-1:0] instr_out,
  output logic              hold,
  output logic [ADDR_W-1:0] pm_address,
  input  logic [DATA_W-1:0] pm_data,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);

  localparam int unsigned OffsetW = offset_w(LINE_WORDS);
  localparam int unsigned IndexW  = index_w(NUM_LINES);
  localparam int          TagWRaw = tag_w(ADDR_W, NUM_LINES, LINE_WORDS);
  localparam int unsigned TagW    = (TagWRaw < 1) ? 1 : TagWRaw;
  localparam int unsigned BaseW   = TagW + IndexW;

  if (TagWRaw < 1) begin : gen_bad_cfg
    $error("multi_line_icache: ADDR_W too small for NUM_LINES and LINE_WORDS");
  end

  icache_state_e state_q, state_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TagW-1:0]      tag_q  [NUM_LINES];
  logic [DATA_W-1:0]    data_q [NUM_LINES][LINE_WORDS];
  logic [BaseW-1:0]     fill_base_q, fill_base_d;

  logic [OffsetW-1:0] a_offset;
  logic [IndexW-1:0]  a_index;
  logic [TagW-1:0]    a_tag;
  logic [IndexW-1:0]  fill_index;
  logic [TagW-1:0]    fill_tag;
  logic               idle, lookup, line_ok, hit, miss_start;
  logic               fill_we, fill_done;
  logic [OffsetW-1:0] fill_off;

  assign a_offset   = cpu_addr[OffsetW-1:0];
  assign a_index    = cpu_addr[OffsetW +: IndexW];
  assign a_tag      = cpu_addr[ADDR_W-1 -: TagW];
  assign fill_index = fill_base_q[IndexW-1:0];
  assign fill_tag   = fill_base_q[BaseW-1:IndexW];

  // Flush outranks lookup: a flushed fetch stalls one cycle and retries.
  assign idle       = (state_q == StIdle);
  assign lookup     = idle && fetch_en && !flush;
  assign line_ok    = valid_q[a_index] && (tag_q[a_index] == a_tag);
  assign hit        = lookup && line_ok;
  assign miss_start = lookup && !line_ok;

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    fill_base_d = fill_base_q;
    unique case (state_q)
      StIdle: begin
        if (miss_start) begin
          state_d          = StFill;
          fill_base_d      = {a_tag, a_index};
          valid_d[a_index] = 1'b0;
        end
      end
      StFill: begin
        if (flush || fill_done) begin
          state_d = StIdle;
        end
        if (fill_done) begin
          valid_d[fill_index] = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (flush) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      state_q <= StIdle;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

  // Tag and data storage are deliberately left out of reset.
  always_ff @(posedge clk) begin
    fill_base_q <= fill_base_d;
    if (fill_we) begin
      data_q[fill_index][fill_off] <= pm_data;
    end
    if (fill_done) begin
      tag_q[fill_index] <= fill_tag;
    end
  end

  icache_fill_ctrl #(
    .AddrW   (ADDR_W),
    .OffsetW (OffsetW)
  ) u_fill_ctrl (
    .clk_i        (clk),
    .rst_ni       (sync_reset_n),
    .start_i      (miss_start),
    .active_i     (state_q == StFill),
    .abort_i      (flush),
    .base_i       (fill_base_d),
    .pm_address_o (pm_address),
    .we_o         (fill_we),
    .wr_off_o     (fill_off),
    .done_o       (fill_done)
  );

  assign instr_out = (sync_reset_n && hit) ? data_q[a_index][a_offset] : NOP_OP;
  assign hold      = sync_reset_n && ((state_q == StFill) || (idle && fetch_en && !hit));

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  // Saturating; flush leaves the counts alone.
  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit && (hit_cnt_q != 16'hFFFF)) begin
        hit_cnt_q <= hit_cnt_q + 16'd1;
      end
      if (miss_start && (miss_cnt_q != 16'hFFFF)) begin
        miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_multi_line_icache.sv
// Directed, table-driven bench for multi_line_icache (default parameters).
module tb_multi_line_icache;

  localparam logic [7:0] Nop = 8'hC8;

  logic        clk = 1'b0;
  logic        sync_reset_n;
  logic [7:0]  cpu_addr;
  logic        fetch_en;
  logic        flush;
  logic [7:0]  instr_out;
  logic        hold;
  logic [7:0]  pm_address;
  logic [7:0]  pm_data = 8'h00;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] memf(input logic [7:0] a);
    return (a * 8'd3) ^ 8'h5A;
  endfunction

  // Program memory: data valid one cycle after the address.
  always @(posedge clk) pm_data <= memf(pm_address);

  multi_line_icache dut (
    .clk          (clk),
    .sync_reset_n (sync_reset_n),
    .cpu_addr     (cpu_addr),
    .fetch_en     (fetch_en),
    .flush        (flush),
    .instr_out    (instr_out),
    .hold         (hold),
    .pm_address   (pm_address),
    .pm_data      (pm_data),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  typedef struct {
    logic [7:0] addr;
    logic       fe;
    logic       fl;
    logic       exp_hold;
    logic [7:0] exp_instr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t hv(input logic [7:0] a);
    vec_t v;
    v.addr = a; v.fe = 1'b1; v.fl = 1'b0; v.exp_hold = 1'b0; v.exp_instr = memf(a);
    return v;
  endfunction

  function automatic vec_t mv(input logic [7:0] a, input logic fe, input logic fl,
                              input logic h, input logic [7:0] ins);
    vec_t v;
    v.addr = a; v.fe = fe; v.fl = fl; v.exp_hold = h; v.exp_instr = ins;
    return v;
  endfunction

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      cpu_addr = vecs[i].addr;
      fetch_en = vecs[i].fe;
      flush    = vecs[i].fl;
      #1;
      chk($sformatf("vec%0d_hold", i), 32'(hold), 32'(vecs[i].exp_hold));
      chk($sformatf("vec%0d_instr", i), 32'(instr_out), 32'(vecs[i].exp_instr));
      cyc();
    end
    flush = 1'b0;
  endtask

  // Full miss: 1 miss cycle + 17 fill cycles stalled, then the retry hits.
  task automatic miss_fill(input logic [7:0] a);
    cpu_addr = a;
    fetch_en = 1'b1;
    flush    = 1'b0;
    #1;
    chk($sformatf("miss_hold_%0h", a), 32'(hold), 32'd1);
    chk($sformatf("miss_nop_%0h", a), 32'(instr_out), 32'(Nop));
    cyc();
    for (int k = 0; k <= 16; k++) begin
      #1;
      chk($sformatf("fill_hold_%0h_%0d", a, k), 32'(hold), 32'd1);
      chk($sformatf("fill_nop_%0h_%0d", a, k), 32'(instr_out), 32'(Nop));
      if (k < 16) begin
        chk($sformatf("fill_pm_addr_%0h_%0d", a, k), 32'(pm_address), 32'({a[7:4], 4'(k)}));
      end
      cyc();
    end
    #1;
    chk($sformatf("retry_hold_%0h", a), 32'(hold), 32'd0);
    chk($sformatf("retry_instr_%0h", a), 32'(instr_out), 32'(memf(a)));
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Vector table.
    for (int a = 1; a <= 15; a++) vecs.push_back(hv(8'(a)));      // 0..14
    vecs.push_back(mv(8'h00, 1'b0, 1'b0, 1'b0, Nop));             // 15
    vecs.push_back(hv(8'h00));                                    // 16
    vecs.push_back(hv(8'h10));                                    // 17
    vecs.push_back(hv(8'h20));                                    // 18
    vecs.push_back(hv(8'h30));                                    // 19
    vecs.push_back(hv(8'h1F));                                    // 20
    vecs.push_back(hv(8'h2A));                                    // 21
    vecs.push_back(hv(8'h05));                                    // 22
    vecs.push_back(hv(8'h4A));                                    // 23
    vecs.push_back(hv(8'h3C));                                    // 24
    vecs.push_back(mv(8'h05, 1'b1, 1'b1, 1'b1, Nop));             // 25

    // Reset.
    sync_reset_n = 1'b0;
    fetch_en     = 1'b1;
    flush        = 1'b0;
    cpu_addr     = 8'h00;
    #1;
    chk("rst_hold", 32'(hold), 32'd0);
    chk("rst_instr", 32'(instr_out), 32'(Nop));
    cyc();
    cyc();
    chk("rst_pm_addr", 32'(pm_address), 32'd0);
    chk("rst_hit_count", 32'(hit_count), 32'd0);
    chk("rst_miss_count", 32'(miss_count), 32'd0);
    sync_reset_n = 1'b1;

    // Cold miss on line 0, then the rest of the line hits.
    miss_fill(8'h00);
    run_vecs(0, 15);
`ifdef ICACHE_STATS_EN
    chk("stats_hit_line0", 32'(hit_count), 32'd16);
    chk("stats_miss_line0", 32'(miss_count), 32'd1);
`else
    chk("stats_hit_off", 32'(hit_count), 32'd0);
    chk("stats_miss_off", 32'(miss_count), 32'd0);
`endif

    // Fill the other three lines; all four stay resident.
    miss_fill(8'h10);
    miss_fill(8'h20);
    miss_fill(8'h30);
    run_vecs(16, 21);

    // Conflict on index 0.
    run_vecs(22, 22);
    miss_fill(8'h45);
    run_vecs(23, 24);
    miss_fill(8'h05);

    // Flush in IDLE over a hit: stall one cycle, no fill; the retry then misses.
    run_vecs(25, 25);
    miss_fill(8'h05);

    // Flush aborts a fill at step 7.
    cpu_addr = 8'h60;
    fetch_en = 1'b1;
    #1;
    chk("abort_miss_hold", 32'(hold), 32'd1);
    cyc();
    for (int k = 0; k < 7; k++) cyc();
    flush = 1'b1;
    #1;
    chk("abort_fc7_pm_addr", 32'(pm_address), 32'h67);
    chk("abort_fc7_hold", 32'(hold), 32'd1);
    cyc();
    flush    = 1'b0;
    fetch_en = 1'b0;
    #1;
    chk("abort_idle_hold", 32'(hold), 32'd0);
    cyc();
    miss_fill(8'h60);
    miss_fill(8'h10);

    // Reset in the middle of a fill.
    cpu_addr = 8'h70;
    fetch_en = 1'b1;
    cyc();
    for (int k = 0; k < 5; k++) cyc();
    sync_reset_n = 1'b0;
    #1;
    chk("midrst_hold", 32'(hold), 32'd0);
    chk("midrst_instr", 32'(instr_out), 32'(Nop));
    cyc();
    chk("midrst_pm_addr", 32'(pm_address), 32'd0);
    chk("midrst_hold2", 32'(hold), 32'd0);
    chk("midrst_hit_count", 32'(hit_count), 32'd0);
    chk("midrst_miss_count", 32'(miss_count), 32'd0);
    sync_reset_n = 1'b1;
    miss_fill(8'h60);
`ifdef ICACHE_STATS_EN
    chk("stats_hit_post_rst", 32'(hit_count), 32'd1);
    chk("stats_miss_post_rst", 32'(miss_count), 32'd1);
`else
    chk("stats_hit_off_end", 32'(hit_count), 32'd0);
    chk("stats_miss_off_end", 32'(miss_count), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
